cia_timer_gen: RTL and testbench

Parametrised interval timer: the next-generation replacement for the fixed 16-bit Timer A/B datapath in the CIA core. Provides a WIDTH-bit down-counter with a byte-writable reload latch, one-shot/continuous run modes, force load, pulse/toggle port output, and a registered count-enable pipeline. Two instances (A and B, B cascaded from A's underflow by the parent) sit between the register file and the interrupt/port logic. All counter activity advances on the phi2 tick strobe.

---
 rtl/cia_timer_gen.sv | 72 +++++++
 tb/tb_cia_timer_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cia_timer_gen.sv
// cia_timer_gen: WIDTH-bit interval down-counter with byte-writable reload latch,
// one-shot/continuous run modes, force load and pulse/toggle port output.
module cia_timer_gen #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_LATCH = '1,
  parameter int NBYTES = WIDTH / 8,
  localparam int SW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_en,
  input  logic [SW-1:0]    wr_sel,
  input  logic [7:0]       wr_data,
  input  logic [3:0]       ctrl,
  input  logic             runmode,
  input  logic             ctrl_wr,
  output logic [WIDTH-1:0] counter,
  output logic [WIDTH-1:0] latch,
  output logic             underflow,
  output logic             start_clr,
  output logic             pb_out
);
  localparam int START = 3, OUTMODE = 2, FORCE = 1, COUNT = 0;
  logic [WIDTH-1:0] r_counter, r_latch, w_latch_nxt, w_counter_nxt;
  logic r_load_pend, r_cnt_q, r_halt, r_start_q, r_pulse, r_toggle, r_pb;
  logic w_start, w_load_req, w_start_rise, w_cnt_nxt, w_halt_nxt, w_pulse_nxt, w_toggle_nxt;
  assign w_start = ctrl[START];
  always_comb begin
    w_latch_nxt = r_latch;
    for (int b = 0; b < NBYTES; b++)
      if (wr_en && wr_sel == SW'(b)) w_latch_nxt[b*8 +: 8] = wr_data;
  end
  assign w_load_req   = (wr_en && wr_sel == SW'(NBYTES - 1) && !w_start) || (ctrl_wr && ctrl[FORCE]);
  assign w_start_rise = ctrl_wr & w_start & ~r_start_q;
  assign underflow    = tick & ~r_load_pend & r_cnt_q & (r_counter == '0);
  assign start_clr    = underflow & runmode;
  // reload paths take the latch including any byte written on this same edge
  assign w_counter_nxt = !tick ? r_counter :
                         (r_load_pend || underflow) ? w_latch_nxt :
                         r_cnt_q ? r_counter - WIDTH'(1) : r_counter;
  // a finished one-shot stays halted until the parent drops start
  assign w_halt_nxt   = start_clr ? 1'b1 : !w_start ? 1'b0 : r_halt;
  assign w_cnt_nxt    = tick ? (ctrl[COUNT] & w_start & ~r_halt & ~start_clr) : r_cnt_q;
  assign w_pulse_nxt  = underflow ? 1'b1 : tick ? 1'b0 : r_pulse;
  assign w_toggle_nxt = w_start_rise ? 1'b1 : underflow ? ~r_toggle : r_toggle;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_counter   <= RESET_LATCH;
      r_latch     <= RESET_LATCH;
      r_load_pend <= 1'b0;
      r_cnt_q     <= 1'b0;
      r_halt      <= 1'b0;
      r_start_q   <= 1'b0;
      r_pulse     <= 1'b0;
      r_toggle    <= 1'b1;
      r_pb        <= 1'b0;
    end else begin
      r_counter   <= w_counter_nxt;
      r_latch     <= w_latch_nxt;
      r_load_pend <= w_load_req | (r_load_pend & ~tick);
      r_cnt_q     <= w_cnt_nxt;
      r_halt      <= w_halt_nxt;
      r_start_q   <= w_start;
      r_pulse     <= w_pulse_nxt;
      r_toggle    <= w_toggle_nxt;
      r_pb        <= ctrl[OUTMODE] ? w_toggle_nxt : w_pulse_nxt;
    end
  assign counter = r_counter;
  assign latch   = r_latch;
  assign pb_out  = r_pb;
endmodule

// File: tb/tb_cia_timer_gen.sv
// tb_cia_timer_gen: scoreboard bench; each tick pushes the expected pre-edge
// counter/underflow/start_clr/pb_out, a negedge monitor pops and compares.
module tb_cia_timer_gen;
  localparam logic [3:0] S = 4'b1000, O = 4'b0100, F = 4'b0010, C = 4'b0001;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, wr_en = 1'b0, runmode = 1'b0, ctrl_wr = 1'b0;
  logic [0:0] wr_sel = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] ctrl = '0;
  logic [15:0] counter, latch;
  logic underflow, start_clr, pb_out;
  logic b_tick = 1'b0, b_wr_en = 1'b0, b_ctrl_wr = 1'b0;
  logic [1:0] b_wr_sel = '0;
  logic [7:0] b_wr_data = '0;
  logic [3:0] b_ctrl = '0;
  logic [23:0] b_counter, b_latch;
  logic b_underflow, b_start_clr, b_pb_out;
  typedef struct { logic [15:0] c; logic u, s, p; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, n_tick = 0;

  cia_timer_gen #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .ctrl(ctrl), .runmode(runmode), .ctrl_wr(ctrl_wr), .counter(counter), .latch(latch),
    .underflow(underflow), .start_clr(start_clr), .pb_out(pb_out));

  cia_timer_gen #(.WIDTH(24)) dut_b (
    .clk(clk), .rst(rst), .tick(b_tick), .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
    .ctrl(b_ctrl), .runmode(1'b0), .ctrl_wr(b_ctrl_wr), .counter(b_counter), .latch(b_latch),
    .underflow(b_underflow), .start_clr(b_start_clr), .pb_out(b_pb_out));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  always @(negedge clk) if (tick && !rst) begin
    exp_t e;
    n_tick++;
    if (sb.size() == 0) chk($sformatf("t%0d_sb_empty", n_tick), 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      chk($sformatf("t%0d_counter", n_tick), {16'd0, counter}, {16'd0, e.c});
      chk($sformatf("t%0d_underflow", n_tick), {31'd0, underflow}, {31'd0, e.u});
      chk($sformatf("t%0d_start_clr", n_tick), {31'd0, start_clr}, {31'd0, e.s});
      chk($sformatf("t%0d_pb_out", n_tick), {31'd0, pb_out}, {31'd0, e.p});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [0:0] sel, input logic [7:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic bwr(input logic [1:0] sel, input logic [7:0] d);
    b_wr_en = 1'b1; b_wr_sel = sel; b_wr_data = d;
    step();
    b_wr_en = 1'b0;
  endtask

  task automatic cw(input logic [3:0] c);
    ctrl = c; ctrl_wr = 1'b1;
    step();
    ctrl_wr = 1'b0; ctrl = c & ~F;
  endtask

  task automatic tk(input logic [15:0] c, input logic u, input logic s, input logic p);
    exp_t e;
    e.c = c; e.u = u; e.s = s; e.p = p;
    sb.push_back(e);
    tick = 1'b1;
    step();
    tick = 1'b0; wr_en = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    chk("rst_counter", {16'd0, counter}, 32'h0000_FFFF);
    chk("rst_latch", {16'd0, latch}, 32'h0000_FFFF);
    chk("rst_pb", {31'd0, pb_out}, 32'd0);
    chk("rst_uf", {31'd0, underflow}, 32'd0);
    chk("rst_b_counter", {8'd0, b_counter}, 32'h00FF_FFFF);
    rst = 1'b0;
    step();
    // continuous, latch 3
    wr(1'b0, 8'h03);
    wr(1'b1, 8'h00);
    chk("cont_latch", {16'd0, latch}, 32'd3);
    cw(S | F | C);
    tk(16'hFFFF, 0, 0, 0);
    tk(3, 0, 0, 0); tk(2, 0, 0, 0); tk(1, 0, 0, 0); tk(0, 1, 0, 0);
    tk(3, 0, 0, 1); tk(2, 0, 0, 0); tk(1, 0, 0, 0); tk(0, 1, 0, 0);
    tk(3, 0, 0, 1);
    // asynchronous reset mid-count with a tick present
    #3 rst = 1'b1; tick = 1'b1;
    #1;
    chk("mid_rst_counter", {16'd0, counter}, 32'h0000_FFFF);
    chk("mid_rst_latch", {16'd0, latch}, 32'h0000_FFFF);
    chk("mid_rst_pb", {31'd0, pb_out}, 32'd0);
    chk("mid_rst_uf", {31'd0, underflow}, 32'd0);
    tick = 1'b0; ctrl = '0;
    step(); step();
    rst = 1'b0;
    step();
    // one-shot, latch 2, start left high by parent
    runmode = 1'b1;
    wr(1'b0, 8'h02);
    wr(1'b1, 8'h00);
    cw(S | C);
    tk(16'hFFFF, 0, 0, 0); tk(2, 0, 0, 0); tk(1, 0, 0, 0); tk(0, 1, 1, 0);
    tk(2, 0, 0, 1); tk(2, 0, 0, 0); tk(2, 0, 0, 0);
    ctrl = '0; runmode = 1'b0;
    step();
    // toggle mode, latch 1
    ctrl = O;
    wr(1'b0, 8'h01);
    wr(1'b1, 8'h00);
    cw(S | O | C);
    tk(2, 0, 0, 1); tk(1, 0, 0, 1); tk(0, 1, 0, 1); tk(1, 0, 0, 0);
    tk(0, 1, 0, 0); tk(1, 0, 0, 1); tk(0, 1, 0, 1); tk(1, 0, 0, 0);
    ctrl = '0;
    step();
    // latch 0 continuous, then low byte written on an underflow edge
    wr(1'b0, 8'h00);
    wr(1'b1, 8'h00);
    cw(S | C);
    tk(0, 0, 0, 0); tk(0, 1, 0, 0); tk(0, 1, 0, 1);
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 8'h05;
    tk(0, 1, 0, 1);
    tk(5, 0, 0, 1); tk(4, 0, 0, 0);
    chk("sim_latch", {16'd0, latch}, 32'd5);
    ctrl = '0;
    step();
    // 24-bit high-byte write: loads while stopped, not while started
    bwr(2'd0, 8'h10); bwr(2'd1, 8'h00); bwr(2'd2, 8'h00);
    chk("b_latch1", {8'd0, b_latch}, 32'h10);
    b_tick = 1'b1; step(); b_tick = 1'b0; step();
    chk("b_counter1", {8'd0, b_counter}, 32'h10);
    b_ctrl = S;
    bwr(2'd0, 8'h20); bwr(2'd1, 8'h00); bwr(2'd2, 8'h00);
    b_tick = 1'b1; step(); b_tick = 1'b0; step();
    chk("b_counter2", {8'd0, b_counter}, 32'h10);
    chk("b_latch2", {8'd0, b_latch}, 32'h20);
    repeat (3) step();
    chk("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
